// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//   Receives a standard I2S stereo stream (BCK/WS/SDATA from an external ADC,
//   asynchronous to CLK) and presents each completed left+right frame on
//   DATA_L/DATA_R with a VALID/READY handshake.
//
//   All inputs are resynchronised into the CLK domain. WS and SDATA are
//   sampled on a rising-edge strobe of the synchronised BCK. CLK must run
//   at least 4x faster than BCK.
//
//   Optional feature macro: I2S_RX_OVERRUN_EN
//     defined   : a frame completing while VALID=1 and READY=0 is dropped,
//                 the held frame is kept and OVERRUN sets (sticky until RST).
//     undefined : the new frame overwrites the held one, VALID stays 1 and
//                 OVERRUN is tied low.
// -----------------------------------------------------------------------------
module i2s_receiver #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BCK,
  input  logic                 WS,
  input  logic                 SDATA,
  output logic [0:BUS_WIDTH-1] DATA_L,
  output logic [0:BUS_WIDTH-1] DATA_R,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 OVERRUN
);

  // Bit counter must be able to hold BUS_WIDTH itself so it can saturate
  // there and ignore any extra bits of a long slot.
  localparam int              CNT_W   = $clog2(BUS_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUS_WIDTH);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    LEFT_SEEN = 2'd1,
    LOCKED    = 2'd2
  } sync_state_t;

  // Synchroniser flops
  logic bck_s1_r;
  logic bck_s2_r;
  logic bck_s3_r;
  logic ws_s1_r;
  logic ws_s2_r;
  logic sd_s1_r;
  logic sd_s2_r;

  // Bit-level receive state
  logic                 ws_prev_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [0:BUS_WIDTH-1] word_r;
  logic [0:BUS_WIDTH-1] word_next_s;

  // Word/frame assembly state
  sync_state_t          state_r;
  logic                 left_valid_r;
  logic [0:BUS_WIDTH-1] left_hold_r;
  logic [0:BUS_WIDTH-1] right_hold_r;
  logic                 frame_pend_r;

  // Output registers
  logic [0:BUS_WIDTH-1] data_l_r;
  logic [0:BUS_WIDTH-1] data_r_r;
  logic                 valid_r;
  logic                 overrun_r;

  // Decoded strobe and word-boundary events
  logic bck_rise_s;
  logic ws_edge_s;
  logic ws_fall_s;
  logic ws_rise_s;

  // Bring BCK, WS and SDATA into the CLK domain; the third BCK flop gives
  // the previous synchronised level for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bck_s1_r <= 1'b0;
      bck_s2_r <= 1'b0;
      bck_s3_r <= 1'b0;
      ws_s1_r  <= 1'b0;
      ws_s2_r  <= 1'b0;
      sd_s1_r  <= 1'b0;
      sd_s2_r  <= 1'b0;
    end else begin
      bck_s1_r <= BCK;
      bck_s2_r <= bck_s1_r;
      bck_s3_r <= bck_s2_r;
      ws_s1_r  <= WS;
      ws_s2_r  <= ws_s1_r;
      sd_s1_r  <= SDATA;
      sd_s2_r  <= sd_s1_r;
    end
  end

  // One-CLK strobe per BCK rising edge, and WS change classification.
  // A WS change marks the LSB slot of the word that is ending.
  assign bck_rise_s = bck_s2_r & ~bck_s3_r;
  assign ws_edge_s  = bck_rise_s & (ws_s2_r ^ ws_prev_r);
  assign ws_fall_s  = ws_edge_s & ~ws_s2_r;
  assign ws_rise_s  = ws_edge_s & ws_s2_r;

  // Current word with the bit sampled on this strobe inserted at the
  // counter position (MSB first); positions past BUS_WIDTH are dropped.
  always_comb begin
    word_next_s = word_r;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      if (bit_cnt_r == CNT_W'(i)) begin
        word_next_s[i] = sd_s2_r;
      end else begin
        word_next_s[i] = word_r[i];
      end
    end
  end

  // Per-word bit capture: accumulate on each strobe, restart on a boundary
  // so a short word stays left-aligned with zero LSBs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ws_prev_r <= 1'b0;
      bit_cnt_r <= {CNT_W{1'b0}};
      word_r    <= {BUS_WIDTH{1'b0}};
    end else if (bck_rise_s) begin
      ws_prev_r <= ws_s2_r;
      if (ws_edge_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
        word_r    <= {BUS_WIDTH{1'b0}};
      end else begin
        word_r <= word_next_s;
        if (bit_cnt_r < CNT_MAX) begin
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
      end
    end else begin
      ws_prev_r <= ws_prev_r;
      bit_cnt_r <= bit_cnt_r;
      word_r    <= word_r;
    end
  end

  // Frame sync FSM: after reset the receiver hunts for a left word start,
  // then a right word start, and only then collects frames. The first frame
  // emitted is the first whose left word starts after LOCKED is reached,
  // tracked by left_valid_r.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= HUNT;
      left_valid_r <= 1'b0;
      left_hold_r  <= {BUS_WIDTH{1'b0}};
      right_hold_r <= {BUS_WIDTH{1'b0}};
      frame_pend_r <= 1'b0;
    end else begin
      frame_pend_r <= 1'b0;
      case (state_r)
        HUNT: begin
          if (ws_fall_s) begin
            state_r <= LEFT_SEEN;
          end else begin
            state_r <= HUNT;
          end
        end
        LEFT_SEEN: begin
          if (ws_rise_s) begin
            state_r <= LOCKED;
          end else begin
            state_r <= LEFT_SEEN;
          end
        end
        LOCKED: begin
          state_r <= LOCKED;
          if (ws_rise_s) begin
            left_hold_r  <= word_next_s;
            left_valid_r <= 1'b1;
          end else if (ws_fall_s && left_valid_r) begin
            right_hold_r <= word_next_s;
            frame_pend_r <= 1'b1;
          end else begin
            left_hold_r  <= left_hold_r;
            right_hold_r <= right_hold_r;
          end
        end
        default: begin
          state_r      <= HUNT;
          left_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake: load a completed frame one CLK after it is detected,
  // clear VALID on a transfer unless a new frame loads on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_l_r  <= {BUS_WIDTH{1'b0}};
      data_r_r  <= {BUS_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (frame_pend_r) begin
`ifdef I2S_RX_OVERRUN_EN
      if (valid_r && !READY) begin
        // Consumer still holds off: keep the old frame, flag the drop.
        overrun_r <= 1'b1;
      end else begin
        data_l_r <= left_hold_r;
        data_r_r <= right_hold_r;
        valid_r  <= 1'b1;
      end
`else
      data_l_r  <= left_hold_r;
      data_r_r  <= right_hold_r;
      valid_r   <= 1'b1;
      overrun_r <= 1'b0;
`endif
    end else if (valid_r && READY) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign DATA_L  = data_l_r;
  assign DATA_R  = data_r_r;
  assign VALID   = valid_r;
  assign OVERRUN = overrun_r;

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16: sample width per channel, in bits.
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port BCK, input, 1 bit: I2S bit clock from the external ADC, asynchronous to CLK.
REQ-005 SHALL have port WS, input, 1 bit: I2S word select; 0 = left, 1 = right.
REQ-006 SHALL have port SDATA, input, 1 bit: I2S serial data, MSB first.
REQ-007 SHALL have port DATA_L, output, BUS_WIDTH bits ([0:BUS_WIDTH-1], bit 0 = MSB): left sample.
REQ-008 SHALL have port DATA_R, output, BUS_WIDTH bits ([0:BUS_WIDTH-1], bit 0 = MSB): right sample.
REQ-009 SHALL have port VALID, output, 1 bit: DATA_L/DATA_R hold an untransferred frame.
REQ-010 SHALL have port READY, input, 1 bit: consumer accepts the frame.
REQ-011 SHALL have port OVERRUN, output, 1 bit: sticky flag, a frame was dropped.

Function
REQ-012 SHALL pass BCK, WS and SDATA each through a 2-flop CLK synchronizer; a 3rd BCK flop SHALL form a rising-edge strobe (bck_s2 & !bck_s3).
REQ-013 SHALL sample synchronized WS and SDATA only on the BCK rising strobe; CLK frequency SHALL be at least 4x BCK.
REQ-014 SHALL treat a change in sampled WS between consecutive strobes as a word boundary; the bit sampled on that same strobe is the LSB slot of the previous channel (standard I2S one-BCK delay).
REQ-015 SHALL keep a per-word bit counter: bits 0..BUS_WIDTH-1 are stored MSB first, bits beyond BUS_WIDTH are ignored, and a word shorter than BUS_WIDTH is left-aligned with zero-filled LSBs.
REQ-016 SHALL latch a completed left word (WS 0->1 boundary) into an internal left-hold register.
REQ-017 SHALL treat a WS 1->0 boundary as frame complete, loading left-hold and the right word into DATA_L/DATA_R and setting VALID on the next CLK edge.
REQ-018 SHALL have a 3-state sync FSM: HUNT (discard all bits) -> on WS 1->0 boundary -> LEFT_SEEN; LEFT_SEEN -> on WS 0->1 boundary -> LOCKED; only LOCKED emits frames.
REQ-019 SHALL make VALID rise 4 CLK after the pin BCK rising edge that completes a frame, with +1 CLK synchronizer uncertainty.
REQ-020 SHALL complete a transfer when VALID & READY on a CLK edge; VALID SHALL then clear unless a new frame completes on that same edge, in which case the new data loads and VALID stays 1.
REQ-021 SHALL hold DATA_L/DATA_R stable while VALID=1 and no transfer occurs (except as REQ-031 allows).
REQ-022 SHALL leave DATA_L/DATA_R unchanged after a transfer until the next frame.

Reset
REQ-023 SHALL, while RST=1 on a CLK edge, clear DATA_L, DATA_R, VALID, OVERRUN, the left-hold register, the shift register, the bit counter and all synchronizer flops, and set the FSM to HUNT.
REQ-024 SHALL, on RST mid-frame, discard the partial frame; the first frame after release is the first complete left+right pair that starts after reaching LOCKED.
REQ-025 SHALL give RST priority over every other event in the same cycle.

Configuration
REQ-026 SHALL use the macro I2S_RX_OVERRUN_EN.
REQ-027 SHALL, with I2S_RX_OVERRUN_EN defined, drop a frame that completes while VALID=1 and READY=0, retain the old data, and set OVERRUN=1 until RST.
REQ-028 SHALL, without I2S_RX_OVERRUN_EN, overwrite DATA_L/DATA_R with the new frame, keep VALID=1, and tie OVERRUN to 0.

Verification
REQ-029 SHALL cover: BUS_WIDTH=16, BCK=CLK/8, READY=1, frame L=0xA5C3 R=0x1234 -> one VALID pulse with DATA_L=0xA5C3, DATA_R=0x1234.
REQ-030 SHALL cover: READY=0, frames (0xA5C3,0x1234) then (0xFFFF,0x0000) -> with macro: data stays 0xA5C3/0x1234 and OVERRUN=1.
REQ-031 SHALL cover: READY=0, frames (0xA5C3,0x1234) then (0xFFFF,0x0000) -> without macro: data 0xFFFF/0x0000, VALID=1 and OVERRUN=0.
REQ-032 SHALL cover: 24-bit slots L=0xABCDEF R=0x123456 -> DATA_L=0xABCD, DATA_R=0x1234.
REQ-033 SHALL cover: 8-bit slots L=0x81 R=0x7F -> DATA_L=0x8100, DATA_R=0x7F00.
REQ-034 SHALL cover: RST pulsed during a right word, then stream resumes -> no VALID for the partial frame; the first VALID carries the first full pair after LOCKED; OVERRUN=0.
